stack_op_ctrl: RTL

- Multi-cycle sequencer that executes stack instructions (PUSH, POP, CALL, RET) for the accumulator processor.
- Sits directly upstream of the stack-pointer register.
  - Drives that register's write-enable and 16-bit next-value input.
  - Consumes the register's current SP output.
- Issues one data-memory access per operation.
- Returns popped data and program-counter load requests to the datapath.

---
 rtl/stack_op_ctrl.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/stack_op_ctrl.sv
// Purpose : multi-cycle sequencer for PUSH/POP/CALL/RET; drives the SP register and one data-memory access per op.
// Latency : accept to done = 2 cycles + memory wait cycles (1 cycle for a bounds abort); issue interval >= 3 cycles.
// Backpressure: op_ready is high only in IDLE; ACCESS holds mem_req and its fields stable until mem_ready.
//
// Ports:
//   clk, reset                      clock, asynchronous active-high reset
//   op_valid/op_ready/op_code/op_data/pc_in   operation request handshake and operands
//   sp_in -> sp_write/sp_next       SP register current value in, write strobe + new value out
//   mem_req/mem_we/mem_addr/mem_wdata/mem_rdata/mem_ready   single-access memory port
//   done/pop_data/pc_load/pc_next/stack_err   completion results back to the datapath
//
// Optional feature: define STACK_BOUNDS_CHECK_EN to abort overflowing pushes and
// underflowing pops (done + stack_err, no memory access, no SP or PC update).
module stack_op_ctrl #(
  parameter logic [15:0] SP_TOP   = 16'd1016,
  parameter logic [15:0] SP_LIMIT = 16'd512,
  parameter logic [15:0] STEP     = 16'd1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        op_valid,
  output logic        op_ready,
  input  logic [1:0]  op_code,
  input  logic [15:0] op_data,
  input  logic [15:0] pc_in,
  input  logic [15:0] sp_in,
  output logic        sp_write,
  output logic [15:0] sp_next,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ready,
  output logic        done,
  output logic [15:0] pop_data,
  output logic        pc_load,
  output logic [15:0] pc_next,
  output logic        stack_err
);

  localparam logic [1:0] OP_PUSH = 2'd0;
  localparam logic [1:0] OP_POP  = 2'd1;
  localparam logic [1:0] OP_CALL = 2'd2;
  localparam logic [1:0] OP_RET  = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    COMMIT = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [1:0]  op_q;
  logic [15:0] data_q;
  logic [15:0] pc_q;
  logic [15:0] addr_q;
  logic [15:0] newsp_q;
  logic        err_q;
  logic [15:0] pop_data_q;
  logic [15:0] pc_next_q;

  logic accept;
  logic push_like;   // PUSH and CALL write memory and pre-decrement SP
  logic ovf;
  logic unf;
  logic abort;

  assign accept    = (state_q == IDLE) && op_valid;
  assign push_like = ~op_code[0];

  // Bounds are evaluated in 17 bits so they reflect true integer ordering
  // rather than modulo-2^16 wraparound near 0 and 0xFFFF.
  assign ovf = push_like  && ({1'b0, sp_in} < ({1'b0, SP_LIMIT} + {1'b0, STEP}));
  assign unf = !push_like && (({1'b0, sp_in} + {1'b0, STEP}) > {1'b0, SP_TOP});

`ifdef STACK_BOUNDS_CHECK_EN
  assign abort = ovf | unf;
`else
  // Without the check the stack simply wraps; the flags are intentionally dropped.
  logic unused_bounds;
  assign unused_bounds = ovf | unf;
  assign abort         = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Operand capture and result registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q       <= OP_PUSH;
      data_q     <= '0;
      pc_q       <= '0;
      addr_q     <= '0;
      newsp_q    <= '0;
      err_q      <= 1'b0;
      pop_data_q <= '0;
      pc_next_q  <= '0;
    end else begin
      if (accept) begin
        op_q    <= op_code;
        data_q  <= op_data;
        pc_q    <= pc_in;
        err_q   <= abort;
        if (push_like) begin
          addr_q  <= sp_in - STEP;
          newsp_q <= sp_in - STEP;
        end else begin
          addr_q  <= sp_in;
          newsp_q <= sp_in + STEP;
        end
      end
      // Aborted ops never enter ACCESS, so these results stay untouched for them.
      if ((state_q == ACCESS) && mem_ready) begin
        case (op_q)
          OP_POP:  pop_data_q <= mem_rdata;
          OP_RET:  pc_next_q  <= mem_rdata;
          OP_CALL: pc_next_q  <= data_q;
          default: ;
        endcase
      end
    end
  end

  // Next state and outputs
  always_comb begin
    state_d   = state_q;
    op_ready  = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    sp_write  = 1'b0;
    done      = 1'b0;
    pc_load   = 1'b0;
    stack_err = 1'b0;

    case (state_q)
      IDLE: begin
        op_ready = 1'b1;
        if (op_valid) begin
          state_d = abort ? COMMIT : ACCESS;
        end
      end
      ACCESS: begin
        mem_req = 1'b1;
        mem_we  = ~op_q[0];
        if (mem_ready) begin
          state_d = COMMIT;
        end
      end
      COMMIT: begin
        done     = 1'b1;
        sp_write = ~err_q;
        pc_load  = ~err_q && ((op_q == OP_CALL) || (op_q == OP_RET));
`ifdef STACK_BOUNDS_CHECK_EN
        stack_err = err_q;
`endif
        state_d  = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign sp_next   = newsp_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = (op_q == OP_CALL) ? pc_q : data_q;
  assign pop_data  = pop_data_q;
  assign pc_next   = pc_next_q;

endmodule
